// File: rtl/riscv_pkg.sv
// Shared types and constants for the multicycle RISC-V controller: states,
// ALU operation classes, opcodes, funct3 codes, ALU control codes and mux selects.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Codes 0-3 and 5 fit a 3-bit ALUControl; the rest need the 4-bit ALU.
  localparam int unsigned ALU_CODE_W = 4;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'd5;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 4'd6;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 4'd7;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 4'd8;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    aluop_t     alu_op;
    logic       illegal;
  } ctrl_t;

  // Immediate format by opcode; anything unrecognised falls back to I.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    logic [1:0] sel;
    sel = IMM_I;
    case (op)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_JAL:    sel = IMM_J;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's ALU operation class plus funct fields to an
// ALUControl code; the 4-bit variant adds xor, shifts and sltu.
module aludec
  import riscv_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3
) (
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  aluop_t               ALUOp,
  output logic [ALUCTRL_W-1:0] ALUControl
);

  localparam bit EXT_OPS = (ALUCTRL_W >= 4);

  logic [ALU_CODE_W-1:0] w_code;
  logic                  w_unused_op;

  // Only op[5] separates register-register sub from immediate add.
  assign w_unused_op = ^{op[6], op[4:0]};

  always_comb begin
    w_code = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: w_code = ALU_ADD;
      ALUOP_SUB: w_code = ALU_SUB;
      default: begin
        case (funct3)
          F3_ADDSUB: w_code = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
          F3_SLT:    w_code = ALU_SLT;
          F3_OR:     w_code = ALU_OR;
          F3_AND:    w_code = ALU_AND;
          F3_XOR:    if (EXT_OPS) w_code = ALU_XOR;
          F3_SLL:    if (EXT_OPS) w_code = ALU_SLL;
          F3_SR:     if (EXT_OPS) w_code = funct7b5 ? ALU_SRA : ALU_SRL;
          F3_SLTU:   if (EXT_OPS) w_code = ALU_SLTU;
          default:   w_code = ALU_ADD;
        endcase
      end
    endcase
  end

  assign ALUControl = ALUCTRL_W'(w_code);

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RISC-V datapath (lw/sw/R/I/branch/jal),
// with optional memory handshake and extended branch conditions.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3,
  parameter int unsigned MEM_HS    = 0,
  parameter int unsigned BR_EXT    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 Neg,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 illegal
);

  state_t r_state;
  state_t w_next_state;
  ctrl_t  w_ctrl;
  logic   w_mem_go;
  logic   w_taken;

  // Memory states complete immediately unless the handshake is enabled.
  assign w_mem_go = (MEM_HS != 0) ? mem_ready : 1'b1;

  always_comb begin
    w_taken = 1'b0;
    if (BR_EXT != 0) begin
      case (funct3)
        F3_BEQ:           w_taken = Zero;
        F3_BNE:           w_taken = ~Zero;
        F3_BLT, F3_BLTU:  w_taken = Neg;
        F3_BGE, F3_BGEU:  w_taken = ~Neg;
        default:          w_taken = 1'b0;
      endcase
    end else begin
      w_taken = (funct3 == F3_BEQ) & Zero;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:    w_next_state = w_mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_RTYPE:          w_next_state = S_EXECR;
          OP_ITYPE:          w_next_state = S_EXECI;
          OP_BRANCH:         w_next_state = S_BRANCH;
          OP_JAL:            w_next_state = S_JAL;
          default:           w_next_state = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next_state = w_mem_go ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: w_next_state = w_mem_go ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next_state = S_ALUWB;
      S_EXECI:    w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      S_JAL:      w_next_state = S_ALUWB;
      S_TRAP:     w_next_state = S_FETCH;
      default:    w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl            = '0;
    w_ctrl.alu_op     = ALUOP_ADD;
    w_ctrl.result_src = RES_ALUOUT;
    w_ctrl.alu_src_a  = SRCA_PC;
    w_ctrl.alu_src_b  = SRCB_RS2;
    case (r_state)
      S_FETCH: begin
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.result_src = RES_ALURESULT;
        w_ctrl.ir_write   = w_mem_go;
        w_ctrl.pc_write   = w_mem_go;
      end
      S_DECODE: begin
        w_ctrl.alu_src_a = SRCA_OLDPC;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        w_ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl.result_src = RES_DATA;
        w_ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_ctrl.adr_src   = 1'b1;
        w_ctrl.mem_write = w_mem_go;
      end
      S_EXECR: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_op    = ALUOP_SUB;
        w_ctrl.pc_write  = w_taken;
      end
      S_JAL: begin
        w_ctrl.alu_src_a = SRCA_OLDPC;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.pc_write  = 1'b1;
      end
      S_TRAP: begin
        w_ctrl.illegal = 1'b1;
      end
      default: ;
    endcase
    // Strobes stay low for the whole reset; muxes keep showing FETCH.
    if (!reset) begin
      w_ctrl.pc_write  = 1'b0;
      w_ctrl.mem_write = 1'b0;
      w_ctrl.ir_write  = 1'b0;
      w_ctrl.reg_write = 1'b0;
      w_ctrl.illegal   = 1'b0;
    end
  end

  assign PCWrite   = w_ctrl.pc_write;
  assign AdrSrc    = w_ctrl.adr_src;
  assign MemWrite  = w_ctrl.mem_write;
  assign IRWrite   = w_ctrl.ir_write;
  assign RegWrite  = w_ctrl.reg_write;
  assign ResultSrc = w_ctrl.result_src;
  assign ALUSrcA   = w_ctrl.alu_src_a;
  assign ALUSrcB   = w_ctrl.alu_src_b;
  assign illegal   = w_ctrl.illegal;
  assign ImmSrc    = imm_src(op);

  aludec #(
    .ALUCTRL_W (ALUCTRL_W)
  ) u_aludec (
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .ALUOp      (w_ctrl.alu_op),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a default instance (3-bit ALU, no
// handshake, beq only) and an extended one (4-bit ALU, handshake, full branches).
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       Neg;
  logic       mem_ready;

  logic       a_pcw, a_adr, a_mw, a_irw, a_rw, a_ill;
  logic [1:0] a_rs, a_sa, a_sb, a_imm;
  logic [2:0] a_alu;
  logic       b_pcw, b_adr, b_mw, b_irw, b_rw, b_ill;
  logic [1:0] b_rs, b_sa, b_sb, b_imm;
  logic [3:0] b_alu;

  logic [13:0] a_obs, b_obs;
  assign a_obs = {a_pcw, a_adr, a_mw, a_irw, a_rw, a_rs, a_sa, a_sb, a_imm, a_ill};
  assign b_obs = {b_pcw, b_adr, b_mw, b_irw, b_rw, b_rs, b_sa, b_sb, b_imm, b_ill};

  int n_cmp;
  int n_fail;

  multicycle_controller u_dut_a (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .mem_ready(mem_ready),
    .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_mw), .IRWrite(a_irw), .RegWrite(a_rw),
    .ResultSrc(a_rs), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ImmSrc(a_imm),
    .ALUControl(a_alu), .illegal(a_ill)
  );

  multicycle_controller #(.ALUCTRL_W(4), .MEM_HS(1), .BR_EXT(1)) u_dut_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .mem_ready(mem_ready),
    .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_mw), .IRWrite(b_irw), .RegWrite(b_rw),
    .ResultSrc(b_rs), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ImmSrc(b_imm),
    .ALUControl(b_alu), .illegal(b_ill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output word: {PCW,AdrSrc,MemW,IRW,RegW,ResultSrc,SrcA,SrcB,ImmSrc,illegal}
  function automatic logic [13:0] sig(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] imm, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, ill};
  endfunction

  function automatic logic [13:0] e_fetch(input logic [1:0] imm);
    return sig(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, imm, 1'b0);
  endfunction
  function automatic logic [13:0] e_fetch_idle(input logic [1:0] imm);
    return sig(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 1'b0);
  endfunction
  function automatic logic [13:0] e_decode(input logic [1:0] imm);
    return sig(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 1'b0);
  endfunction
  function automatic logic [13:0] e_rs1_imm(input logic [1:0] imm);
    return sig(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 1'b0);
  endfunction
  function automatic logic [13:0] e_rs1_rs2(input logic pcw, input logic [1:0] imm);
    return sig(pcw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm, 1'b0);
  endfunction
  function automatic logic [13:0] e_memread(input logic [1:0] imm);
    return sig(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 1'b0);
  endfunction
  function automatic logic [13:0] e_memwrite(input logic mw);
    return sig(1'b0, 1'b1, mw, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
  endfunction
  function automatic logic [13:0] e_wb(input logic [1:0] rs, input logic [1:0] imm);
    return sig(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rs, 2'b00, 2'b00, imm, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_alu(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed ALUControl %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset with the new instruction fields in place, leave FETCH active.
  task automatic start(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic n);
    @(negedge clk);
    reset = 1'b0; op = o; funct3 = f3; funct7b5 = f7; Zero = z; Neg = n; mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [3:0] ea, input logic [3:0] eb);
    logic [13:0] e_exec;
    e_exec = (o == 7'b0110011) ? e_rs1_rs2(1'b0, 2'b00) : e_rs1_imm(2'b00);
    start(o, f3, f7, 1'b0, 1'b0);
    chk({tag, " fetch"}, a_obs, e_fetch(2'b00));
    step();
    chk({tag, " decode"}, a_obs, e_decode(2'b00));
    step();
    chk({tag, " exec A"}, a_obs, e_exec);
    chk({tag, " exec B"}, b_obs, e_exec);
    chk_alu({tag, " alu A"}, {1'b0, a_alu}, ea);
    chk_alu({tag, " alu B"}, b_alu, eb);
    step();
    chk({tag, " aluwb"}, a_obs, e_wb(2'b00, 2'b00));
    step();
    chk({tag, " refetch"}, b_obs, e_fetch(2'b00));
  endtask

  task automatic run_br(input string tag, input logic [2:0] f3, input logic z,
                        input logic n, input logic ea, input logic eb);
    start(7'b1100011, f3, 1'b0, z, n);
    chk({tag, " fetch"}, a_obs, e_fetch(2'b10));
    step();
    chk({tag, " decode"}, a_obs, e_decode(2'b10));
    step();
    chk({tag, " branch A"}, a_obs, e_rs1_rs2(ea, 2'b10));
    chk({tag, " branch B"}, b_obs, e_rs1_rs2(eb, 2'b10));
    chk_alu({tag, " alu A"}, {1'b0, a_alu}, 4'd1);
    chk_alu({tag, " alu B"}, b_alu, 4'd1);
    step();
    chk({tag, " refetch"}, b_obs, e_fetch(2'b10));
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    Zero = 1'b0; Neg = 1'b0; mem_ready = 1'b1;

    // Held in reset: FETCH muxes, every strobe low
    #12;
    chk("reset A", a_obs, e_fetch_idle(2'b00));
    chk("reset B", b_obs, e_fetch_idle(2'b00));

    // lw without handshake: five one-cycle states, RegWrite only in the fifth
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("lw fetch", a_obs, e_fetch(2'b00));
    step(); chk("lw decode", a_obs, e_decode(2'b00));
    step(); chk("lw memadr", a_obs, e_rs1_imm(2'b00));
    step(); chk("lw memread", a_obs, e_memread(2'b00));
    step(); chk("lw memwb", a_obs, e_wb(2'b01, 2'b00));
    step(); chk("lw refetch", a_obs, e_fetch(2'b00));

    // sw with handshake: ready low 3 cycles in MEMWRITE, 7 cycles total
    start(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    chk("sw fetch", b_obs, e_fetch(2'b01));
    step(); chk("sw decode", b_obs, e_decode(2'b01));
    step(); chk("sw memadr", b_obs, e_rs1_imm(2'b01));
    mem_ready = 1'b0;
    step(); chk("sw wait1", b_obs, e_memwrite(1'b0));
    step(); chk("sw wait2", b_obs, e_memwrite(1'b0));
    step(); chk("sw wait3", b_obs, e_memwrite(1'b0));
    mem_ready = 1'b1;
    #1;
    chk("sw write", b_obs, e_memwrite(1'b1));
    step(); chk("sw refetch", b_obs, e_fetch(2'b01));

    // ALU decode: A is the 3-bit decoder, B the 4-bit one
    run_alu("sub",   7'b0110011, 3'b000, 1'b1, 4'd1, 4'd1);
    run_alu("add",   7'b0110011, 3'b000, 1'b0, 4'd0, 4'd0);
    run_alu("addi",  7'b0010011, 3'b000, 1'b1, 4'd0, 4'd0);
    run_alu("sra",   7'b0110011, 3'b101, 1'b1, 4'd0, 4'd8);
    run_alu("srli",  7'b0010011, 3'b101, 1'b0, 4'd0, 4'd7);
    run_alu("xor",   7'b0110011, 3'b100, 1'b0, 4'd0, 4'd4);
    run_alu("sll",   7'b0110011, 3'b001, 1'b0, 4'd0, 4'd6);
    run_alu("sltu",  7'b0110011, 3'b011, 1'b0, 4'd0, 4'd9);
    run_alu("slt",   7'b0110011, 3'b010, 1'b0, 4'd5, 4'd5);
    run_alu("or",    7'b0110011, 3'b110, 1'b0, 4'd3, 4'd3);
    run_alu("andi",  7'b0010011, 3'b111, 1'b0, 4'd2, 4'd2);

    // Branches: A honours beq only, B the full set
    run_br("beq z1",  3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
    run_br("beq z0",  3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_br("bne z1",  3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    run_br("bne z0",  3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
    run_br("bltu n1", 3'b110, 1'b0, 1'b1, 1'b0, 1'b1);
    run_br("bge n1",  3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
    run_br("blt n0",  3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    run_br("bgeu n0", 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);

    // jal: FETCH, DECODE, JAL, ALUWB
    start(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("jal fetch", a_obs, e_fetch(2'b11));
    step(); chk("jal decode", a_obs, e_decode(2'b11));
    step(); chk("jal jal", a_obs, sig(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 1'b0));
    step(); chk("jal aluwb", a_obs, e_wb(2'b00, 2'b11));
    step(); chk("jal refetch", b_obs, e_fetch(2'b11));

    // Unsupported opcode: one-cycle illegal pulse, no enables
    start(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
    step(); chk("ill decode", a_obs, e_decode(2'b00));
    step();
    chk("ill trap A", a_obs, sig(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
    chk("ill trap B", b_obs, sig(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
    step(); chk("ill refetch", a_obs, e_fetch(2'b00));

    // Handshake hold in FETCH, then reset mid-MEMREAD on B
    @(negedge clk);
    reset = 1'b0; op = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("hs fetch hold", b_obs, e_fetch_idle(2'b00));
    step(); chk("hs fetch hold2", b_obs, e_fetch_idle(2'b00));
    mem_ready = 1'b1;
    #1;
    chk("hs fetch go", b_obs, e_fetch(2'b00));
    step(); chk("hs decode", b_obs, e_decode(2'b00));
    step(); chk("hs memadr", b_obs, e_rs1_imm(2'b00));
    mem_ready = 1'b0;
    step(); chk("hs memread", b_obs, e_memread(2'b00));
    step(); chk("hs memread hold", b_obs, e_memread(2'b00));
    #3;
    reset = 1'b0;
    #1;
    chk("rst mid memread B", b_obs, e_fetch_idle(2'b00));
    chk("rst mid A", a_obs, e_fetch_idle(2'b00));
    mem_ready = 1'b1;
    step(); chk("rst held B", b_obs, e_fetch_idle(2'b00));
    step(); chk("rst held A", a_obs, e_fetch_idle(2'b00));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst release", b_obs, e_fetch(2'b00));
    step(); chk("rst no memwb", b_obs, e_decode(2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 3, ALUControl width; 3 = add/sub/and/or/slt, 4 adds xor/sll/srl/sra/sltu.
REQ-002 SHALL have parameter MEM_HS, default 0, memory handshake; 1 = memory states wait for mem_ready.
REQ-003 SHALL have parameter BR_EXT, default 0, branch set; 0 = beq only, 1 = beq/bne/blt/bge/bltu/bgeu.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 op  in  7  instruction opcode from IR.
REQ-007 funct3  in  3  instruction funct3.
REQ-008 funct7b5  in  1  instruction bit 30.
REQ-009 Zero  in  1  ALU result zero; Neg in 1 ALU sign/less-than flag (used only when BR_EXT=1).
REQ-010 mem_ready  in  1  memory access complete (ignored when MEM_HS=0).
REQ-011 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath enables/selects.
REQ-012 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  datapath muxes (ImmSrc 00 I, 01 S, 10 B, 11 J).
REQ-013 ALUControl  out  ALUCTRL_W  ALU operation.
REQ-014 illegal  out  1  one-cycle pulse on unsupported opcode.

Function
REQ-015 SHALL implement a Moore FSM: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
REQ-016 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp add, ResultSrc=10, PCWrite=1; next DECODE.
REQ-017 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp add; next by op: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BRANCH, 1101111 JAL, else TRAP.
REQ-018 MEMADR: ALUSrcA=10, ALUSrcB=01; next MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
REQ-019 MEMREAD: ResultSrc=00, AdrSrc=1; next MEMWB. MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-020 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1; next FETCH.
REQ-021 EXECR/EXECI: ALUSrcA=10, ALUSrcB=00/01, ALUOp funct; next ALUWB. ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-022 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp sub, ResultSrc=00; PCWrite=1 iff branch taken; next FETCH.
REQ-023 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp add, ResultSrc=00, PCWrite=1; next ALUWB.
REQ-024 TRAP: illegal=1, all enables 0; next FETCH (one cycle).
REQ-025 ImmSrc SHALL be decoded combinationally from op in every state; unused opcodes give 00.
REQ-026 ALUControl: ALUOp add->0, sub->1; funct: funct3 000 -> sub iff funct7b5&op[5] else add, 010 slt, 110 or, 111 and; width-4 adds 100 xor, 001 sll, 101 srl/sra by funct7b5, 011 sltu; unsupported funct3 at width 3 -> add.
REQ-027 Branch taken: BR_EXT=0 Zero for beq, other funct3 not taken; BR_EXT=1 funct3 000 Zero, 001 !Zero, 100/110 Neg, 101/111 !Neg.
REQ-028 MEM_HS=1: FETCH, MEMREAD, MEMWRITE SHALL hold state and drive their muxes while mem_ready=0; IRWrite, PCWrite, MemWrite asserted only in the mem_ready=1 cycle; state advances on that edge.
REQ-029 MEM_HS=0: every state lasts exactly one cycle; lw 5, sw 4, R/I 4, branch 3, jal 4 cycles.
REQ-030 Outputs SHALL be glitch-free functions of state (plus op/funct/flags/mem_ready as specified); no registered outputs.

Reset
REQ-031 reset low SHALL force state FETCH immediately; the FSM and illegal SHALL hold clear while low.
REQ-032 During reset all enables SHALL be 0 (FETCH strobes gated); first FETCH strobes after reset release.
REQ-033 Reset mid-instruction SHALL abandon it with no further RegWrite/MemWrite.

Structure
REQ-034 State enum, ALUOp enum, opcode constants and ALUControl codes SHALL live in package riscv_pkg.
REQ-035 ALU decoding SHALL be sub-module aludec (op, funct3, funct7b5, ALUOp -> ALUControl), parameterised by ALUCTRL_W.

Verification
REQ-036 lw (op 0000011), MEM_HS=0 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 only in cycle 5.
REQ-037 sw, MEM_HS=1, mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 exactly once, 7 cycles total.
REQ-038 beq Zero=1 -> PCWrite in BRANCH; BR_EXT=1 bne Zero=1 -> no PCWrite; bltu Neg=1 -> PCWrite.
REQ-039 R-type sub (funct3 000, funct7b5 1), ALUCTRL_W=4 sra (101,1) -> ALUControl 1 and sra code in EXECR.
REQ-040 op 1111111 -> illegal pulse one cycle, no enables, back to FETCH.
REQ-041 reset low mid-MEMREAD -> FETCH immediately, all enables 0 until release.
